// File: rtl/mem_access_bridge.sv
// Data-side memory bridge between the core memory stage and the data SRAM.
// Adds byte/half/word accesses with byte-lane write strobes, sign/zero extension on loads,
// a parametrised SRAM read latency, a valid/ready request handshake and address-error
// detection with a saturating error counter.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_*               request channel (valid/ready, we, size, sign, addr, wdata)
//   resp_valid/err      one-cycle completion pulse, qualified by address error
//   resp_rdata          extended load data (0 for stores and errors)
//   err_addr/err_count  last faulting address and saturating error count
//   data_sram_*         SRAM port: enable, byte strobes, word address, write/read data
module mem_access_bridge #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RD_LAT      = 1,  // 1..4
  parameter int unsigned ALIGN_CHECK = 1,
  parameter int unsigned ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_sign,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [31:0]         resp_rdata,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_wen,
  output logic [ADDR_W-1:0]   data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  input  logic [31:0]         data_sram_rdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;

  localparam logic [1:0] RdLatM1 = 2'(RD_LAT - 1);

  logic [1:0]          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [1:0]          size_q;
  logic                sign_q;
  logic [1:0]          off_q;
  logic [3:0]          strb_q;
  logic [ADDR_W-1:0]   sram_addr_q;
  logic [31:0]         sram_wdata_q;
  logic                err_pend_q;
  logic [ADDR_W-1:0]   err_addr_q;
  logic [ERRCNT_W-1:0] err_count_q;

  logic        accept;
  logic        misalign;
  logic        addr_err;
  logic [1:0]  off_eff;
  logic [3:0]  strb;
  logic [31:0] wdata_lanes;
  logic        load_resp;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign req_ready = (state_q == StIdle) & ~rst;
  assign accept    = req_valid & req_ready;

  // Request decode: alignment check, effective lane offset, strobes and lane replication.
  always_comb begin
    misalign    = 1'b0;
    off_eff     = 2'b00;
    strb        = 4'b1111;
    wdata_lanes = req_wdata;
    unique case (req_size)
      2'd0: begin
        off_eff     = req_addr[1:0];
        strb        = 4'b0001 << req_addr[1:0];
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        misalign    = req_addr[0];
        off_eff     = {req_addr[1], 1'b0};  // masked when alignment checking is off
        strb        = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      2'd2: misalign = |req_addr[1:0];
      default: misalign = 1'b1;
    endcase
    // Reserved size is an error regardless of the alignment policy.
    addr_err = (req_size == 2'd3) | ((ALIGN_CHECK != 0) & misalign);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (accept && !addr_err) state_d = StAccess;
      StAccess: begin
        if (we_q) begin
          state_d = StIdle;
        end else begin
          state_d = StWait;
          cnt_d   = RdLatM1;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign load_resp = (state_q == StWait) && (cnt_q == 2'd0);

  // Responses are suppressed while rst is high so an aborted access never completes.
  assign resp_valid = ~rst & (err_pend_q | ((state_q == StAccess) & we_q) | load_resp);
  assign resp_err   = ~rst & err_pend_q;

  assign data_sram_en    = (state_q == StAccess);
  assign data_sram_wen   = (data_sram_en & we_q) ? strb_q : 4'b0000;
  assign data_sram_addr  = sram_addr_q;
  assign data_sram_wdata = sram_wdata_q;
  assign err_addr        = err_addr_q;
  assign err_count       = err_count_q;

  // Little-endian lane extraction followed by sign/zero extension.
  always_comb begin
    rd_byte    = data_sram_rdata[{off_q, 3'b000} +: 8];
    rd_half    = off_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    resp_rdata = 32'h0;
    if (!rst && load_resp) begin
      unique case (size_q)
        2'd0:    resp_rdata = {{24{sign_q & rd_byte[7]}}, rd_byte};
        2'd1:    resp_rdata = {{16{sign_q & rd_half[15]}}, rd_half};
        default: resp_rdata = data_sram_rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 2'd0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      sign_q       <= 1'b0;
      off_q        <= 2'd0;
      strb_q       <= 4'd0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0;
      err_pend_q   <= 1'b0;
      err_addr_q   <= '0;
      err_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_pend_q <= accept & addr_err;
      if (accept) begin
        we_q   <= req_we;
        size_q <= req_size;
        sign_q <= req_sign;
        off_q  <= off_eff;
      end
      if (accept && !addr_err) begin
        sram_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
        sram_wdata_q <= wdata_lanes;
        strb_q       <= strb;
      end
      if (accept && addr_err) begin
        err_addr_q <= req_addr;
        if (err_count_q != {ERRCNT_W{1'b1}}) err_count_q <= err_count_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_access_bridge.md
Name: mem_access_bridge

Overview:
Data-side memory bridge between the MIPS core's memory stage and the data SRAM. It is the successor to the fixed word-only, always-enabled data port. It adds byte, halfword and word accesses with byte-lane write strobes, and sign/zero extension on loads. It also adds a parametrised SRAM read latency, a valid/ready request handshake with stall, and address-error detection with a saturating error counter.

Parameters:
ADDR_W, 32, width of request and SRAM address.
RD_LAT, 1, data SRAM read latency in cycles; legal range 1..4.
ALIGN_CHECK, 1, 1 = misaligned access raises an error; 0 = low address bits are masked to natural alignment and the access proceeds.
ERRCNT_W, 8, width of the misalignment error counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  request present.
req_ready  out  1  bridge can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (always an error).
req_sign  in  1  load sign-extend when 1, zero-extend when 0.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-aligned.
resp_valid  out  1  one-cycle completion pulse.
resp_err  out  1  qualifies resp_valid; address error.
resp_rdata  out  32  extended load data; 0 for stores and errors.
err_addr  out  ADDR_W  faulting address, held until the next error.
err_count  out  ERRCNT_W  saturating count of errors.
data_sram_en  out  1  SRAM access enable.
data_sram_wen  out  4  byte write strobes, bit i = byte lane i.
data_sram_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
data_sram_wdata  out  32  lane-replicated store data.
data_sram_rdata  in  32  SRAM read data.

Behaviour:
- Clock and reset: one clock clk; rst is synchronous and active-high.
- Reset values: every registered output is 0 and state is IDLE. req_ready = 0 while rst = 1.
- States: IDLE, ACCESS, WAIT.
- req_ready = 1 only in IDLE (and rst = 0). A handshake is req_valid & req_ready at a clock edge; the request fields are captured then. Requests outside IDLE are ignored and must be held by the core (stall).
- Alignment rules: byte is always OK; half requires addr[0] = 0; word requires addr[1:0] = 0; size 3 always errors, even when ALIGN_CHECK = 0.
- Error path (IDLE, accepted): no SRAM access. Next cycle: resp_valid = 1, resp_err = 1, err_addr = captured address, err_count increments (saturates at all-ones). State remains IDLE, so req_ready stays 1.
- Good path: IDLE -> ACCESS. In ACCESS, data_sram_en = 1 and data_sram_addr = {addr[ADDR_W-1:2], 2'b00}.
- Store strobes: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
- Store wdata: byte replicated 4x, half replicated 2x, word as-is.
- Store completion: resp_valid = 1 in the ACCESS cycle itself, then -> IDLE.
- Load: wen = 0 in ACCESS. The SRAM samples at the end of ACCESS and the bridge enters WAIT with counter = RD_LAT - 1. data_sram_rdata is valid in the cycle RD_LAT cycles after ACCESS. In that cycle: resp_valid = 1, resp_rdata = extracted lane, state -> IDLE.
- Load extraction is little-endian: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16]; then sign- or zero-extend to 32 per req_sign.
- Latency: store accept -> resp = 1 cycle. Load accept -> resp = 1 + RD_LAT cycles. Error accept -> resp = 1 cycle.
- Back-to-back: a new request may be accepted in the first IDLE cycle after resp_valid. Throughput: store 1 request per 2 cycles; load 1 request per RD_LAT + 2 cycles.
- Outside ACCESS, data_sram_en = 0 and wen = 0. addr and wdata hold their last values.
- Reset mid-operation (ACCESS or WAIT): abort. No resp_valid is issued. SRAM en/wen are 0 from the next cycle. err_count and err_addr clear.
- resp_rdata outside a load response is 0.

Test Plan:
- Word store, addr 0x100, wdata 0xDEADBEEF -> ACCESS cycle: en = 1, wen = 4'b1111, addr 0x100, wdata 0xDEADBEEF; resp_valid the same cycle; req_ready back to 1 the next cycle.
- Byte store, addr 0x103, wdata 0x000000AB -> wen = 4'b1000, wdata 0xABABABAB, addr 0x100.
- Loads, RD_LAT = 1, rdata 0x12805634:
  - lb signed at 0x202 -> resp_rdata 0xFFFFFF80 exactly 2 cycles after accept.
  - lhu at 0x202 -> 0x00001280.
  - lh at 0x200 -> 0x00005634.
- Misaligned lw at 0x106, ALIGN_CHECK = 1 -> no en; next cycle resp_err = 1, err_addr 0x106, err_count 0 -> 1. 256 more errors (ERRCNT_W = 8) -> err_count saturates at 0xFF. With ALIGN_CHECK = 0 the same lw accesses 0x104 with no error.
- RD_LAT = 3, lw at 0x40 -> resp_valid 4 cycles after accept; req_ready = 0 in between; req_valid held in those cycles is not accepted.
- rst asserted during WAIT (RD_LAT = 3) -> no resp_valid; en, wen, err_count = 0; req_ready = 1 on the first cycle after rst deasserts.
